// File: rtl/priority_decoder_seq_if.sv
// Bus bundle for priority_decoder_seq.
//
// Purpose: groups the code/handshake inputs and the decoded strobe outputs
// so the decoder and whatever drives it share a single connection.
//
// Signals:
//   y1, y0   encoded code (y1 is the MSB), driven by the master
//   valid    code qualifier, driven by the master
//   clear    synchronous abort of an in-progress pulse, driven by the master
//   ready    decoder can accept a code this cycle, driven by the slave
//   d3..d0   registered one-hot decoded lines, driven by the slave
//   done     one-cycle pulse on the last hold cycle, driven by the slave
//   evt_cnt  8-bit accepted-code counter, only when DECODER_EVT_CNT_EN is defined
//
// Configuration macro: DECODER_EVT_CNT_EN adds the evt_cnt signal.
interface priority_decoder_seq_if;
  logic       y1;
  logic       y0;
  logic       valid;
  logic       clear;
  logic       ready;
  logic       d3;
  logic       d2;
  logic       d1;
  logic       d0;
  logic       done;
`ifdef DECODER_EVT_CNT_EN
  logic [7:0] evt_cnt;

  modport master (
    output y1, y0, valid, clear,
    input  ready, d3, d2, d1, d0, done, evt_cnt
  );

  modport slave (
    input  y1, y0, valid, clear,
    output ready, d3, d2, d1, d0, done, evt_cnt
  );
`else
  modport master (
    output y1, y0, valid, clear,
    input  ready, d3, d2, d1, d0, done
  );

  modport slave (
    input  y1, y0, valid, clear,
    output ready, d3, d2, d1, d0, done
  );
`endif
endinterface

// File: rtl/priority_decoder_seq.sv
// Sequential 2-to-4 decoder: turns an accepted code {y1,y0} into a one-hot
// strobe on d3..d0 lasting HOLD_CYCLES cycles, followed by one all-zero
// guard cycle before the next code can be taken.
//
// Parameters:
//   HOLD_CYCLES  cycles the selected line stays high per accepted code (1..255)
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  priority_decoder_seq_if.slave
//        inputs : y1, y0, valid, clear
//        outputs: ready (combinational), d3..d0, done, evt_cnt (registered)
//
// Configuration macro: DECODER_EVT_CNT_EN enables the 8-bit wrapping
// accepted-code counter on bus.evt_cnt; when undefined it is absent.
module priority_decoder_seq #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  priority_decoder_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // The counter runs HOLD_CYCLES-1 down to 0, so the selected line is high
  // for exactly HOLD_CYCLES cycles.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] hold_cnt;
  logic [7:0] hold_cnt_nxt;
  logic [1:0] code_q;
  logic [1:0] code_nxt;
  logic [3:0] d_q;
  logic [3:0] d_nxt;
  logic       done_q;
  logic       done_nxt;
  logic       accept;

  function automatic logic [3:0] one_hot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

  // ready is forced low while reset is held so nothing upstream sees a
  // handshake during reset.
  assign bus.ready = (state == IDLE) && !rst;
  assign accept    = bus.valid && bus.ready;

  // d and done are computed one cycle ahead so they leave the flops in step
  // with the state they belong to. clear is only examined in HOLD, which is
  // what lets a same-cycle acceptance in IDLE win over it.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    code_nxt     = code_q;
    d_nxt        = 4'b0000;
    done_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt    = HOLD;
          code_nxt     = {bus.y1, bus.y0};
          hold_cnt_nxt = HOLD_LOAD;
          d_nxt        = one_hot({bus.y1, bus.y0});
          done_nxt     = (HOLD_LOAD == 8'd0);
        end
      end
      HOLD: begin
        if (bus.clear) begin
          state_nxt = IDLE;
        end else if (hold_cnt == 8'd0) begin
          state_nxt = GAP;
        end else begin
          hold_cnt_nxt = hold_cnt - 8'd1;
          d_nxt        = one_hot(code_q);
          done_nxt     = (hold_cnt == 8'd1);
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears the outputs at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
      code_q   <= 2'b00;
      d_q      <= 4'b0000;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      code_q   <= code_nxt;
      d_q      <= d_nxt;
      done_q   <= done_nxt;
    end
  end

  assign bus.d3   = d_q[3];
  assign bus.d2   = d_q[2];
  assign bus.d1   = d_q[1];
  assign bus.d0   = d_q[0];
  assign bus.done = done_q;

`ifdef DECODER_EVT_CNT_EN
  logic [7:0] evt_cnt_q;

  // Counts every acceptance and wraps naturally at 8 bits; clear does not
  // touch it, only reset does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_cnt_q <= 8'd0;
    end else if (accept) begin
      evt_cnt_q <= evt_cnt_q + 8'd1;
    end
  end

  assign bus.evt_cnt = evt_cnt_q;
`endif

endmodule

// File: doc/priority_decoder_seq.md
# priority_decoder_seq

Sequential 2-to-4 decoder that reverses the team's 4-to-2 priority encoder. It accepts an encoded code (y1, y0) qualified by valid, and drives the matching one-hot line d3..d0 for a programmable number of cycles. A mandatory all-zero guard cycle follows each pulse. It sits downstream of the encoder and turns encoded priority events back into timed per-line strobes for actuator and indicator logic.

## Interface

Parameters:
- HOLD_CYCLES, 4, number of cycles the selected one-hot line stays high per accepted code; legal range 1..255.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- y1  input  1  code MSB; same meaning as the encoder output.
- y0  input  1  code LSB.
- valid  input  1  code qualifier; the code is offered only while high.
- clear  input  1  synchronous abort of an in-progress pulse.
- ready  output  1  high when a code can be accepted.
- d3, d2, d1, d0  output  1 each  registered one-hot decoded lines.
- done  output  1  single-cycle pulse on the last HOLD cycle of a normally completed pulse.
- evt_cnt  output  8  accepted-code counter; present only under the configuration macro.

## Operation

- States:
  - IDLE: ready=1, d=0.
  - HOLD: d = one-hot of the latched code.
  - GAP: d=0, ready=0, lasts exactly 1 cycle.
- Acceptance: valid && ready at a rising edge.
  - The code {y1,y0} is latched and the hold counter is loaded with HOLD_CYCLES-1.
  - State moves IDLE→HOLD.
- Decode: code 00→d0, 01→d1, 10→d2, 11→d3. Exactly one line is high in HOLD and none otherwise.
- HOLD: the counter decrements each cycle.
  - At 0, done=1 for that cycle and the next state is GAP.
  - The counter is wide enough for 255, i.e. 8 bits.
- GAP→IDLE unconditionally.
- valid=0 in IDLE: state and outputs are unchanged. A code offered while ready=0 is ignored, not queued.
- clear=1:
  - In HOLD: next state is IDLE, d=0 from the next cycle, no done, no GAP.
  - In IDLE or GAP: no effect beyond the normal transition.
  - clear takes precedence over the HOLD counter expiry.
- clear and acceptance in the same IDLE cycle: acceptance wins, because clear only acts in HOLD.
- Reset (async, any state, including mid-HOLD):
  - Outputs immediately: d3..d0=0, done=0, evt_cnt=0 (if present).
  - State goes to IDLE.
  - ready is held at 0 while rst is high and returns to 1 in the first cycle after deassertion.

## Timing

- Acceptance at edge N: the selected d line is high from after edge N through edge N+HOLD_CYCLES. That is HOLD_CYCLES full cycles.
- done is high in the final HOLD cycle.
- The GAP cycle follows, then ready=1 again.
- Minimum spacing between acceptances is HOLD_CYCLES+2 cycles.
- ready is combinational from state and rst. All other outputs are registered.
- HOLD_CYCLES=1: one-cycle pulse, and done coincides with it.

## Configuration

- Macro: DECODER_EVT_CNT_EN.
- Defined:
  - evt_cnt increments by 1 on every acceptance.
  - It wraps 255→0.
  - It is not affected by clear, and is reset only by rst.
- Undefined: the evt_cnt port and the counter are absent. All other behaviour is identical.

## Test plan

- Reset mid-HOLD: assert rst two cycles into a code-10 pulse → d2=0 immediately, ready=0 while rst is high, ready=1 the cycle after release, done never pulses.
- Full sweep, HOLD_CYCLES=4: offer codes 00, 01, 10, 11, each at the first cycle ready=1 → each of d0, d1, d2, d3 is high for exactly 4 cycles, then 1 all-zero GAP cycle, done high once per code, acceptances spaced 6 cycles apart.
- Busy rejection: hold valid=1 with code 11 continuously → accepted only every HOLD_CYCLES+2 cycles; a code change during HOLD does not alter the active line.
- Abort: clear=1 on the 2nd HOLD cycle of code 01 → d1=0 next cycle, no done, no GAP, ready=1 the cycle after the clear.
- Edge parameter, HOLD_CYCLES=1: code 00 → d0 and done high in the same single cycle, then GAP, then ready.
- DECODER_EVT_CNT_EN defined: 257 acceptances → evt_cnt=1 (wrapped); unchanged by clear; 0 after rst.
